tinyalu_arbiter: RTL and testbench
==================================

# tinyalu_arbiter

Round-robin scheduler sharing one tinyalu datapath among `NUM_REQ` requesters. It accepts operation requests (A, B, opcode) over per-requester valid/ready handshakes and sequences the ALU's start/done protocol. It returns each result on a shared response bus tagged with the requester ID. It sits between client logic and the tinyalu instance and is the only driver of the ALU's `start`, `A`, `B` and `opcode` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: watchdog limit in cycles of `alu_start` high without `alu_done`. Used only when the watchdog is compiled in.

- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: request pending, one bit per requester.
- `req_ready`  out  NUM_REQ: one-hot accept pulse.
- `req_a`, `req_b`  in  NUM_REQ x operand_t: operands, one per requester.
- `req_op`  in  NUM_REQ x opcode_t: opcode, one per requester.
- `rsp_valid`  out  1: one-cycle result pulse. There is no backpressure.
- `rsp_id`  out  $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_result`  out  result_t: operation result.
- `rsp_error`  out  1: watchdog abort flag.
- `alu_start`, `alu_a`, `alu_b`, `alu_op`  out: drive the tinyalu `start`, `A`, `B`, `opcode` inputs.
- `alu_result`  in  result_t; `alu_done`  in  1: driven by the tinyalu.

## Operation
- The state machine has three states: IDLE, BUSY, RESP.
- IDLE:
  - If any `req_valid` bit is high, grant requester g, the first set bit scanning upward from `last_grant+1` modulo NUM_REQ.
  - Pulse `req_ready[g]` combinationally in that same cycle.
  - Latch a/b/op/g into holding registers.
  - If op==NOP, go to RESP with result 0. The ALU is not started.
  - Otherwise go to BUSY.
  - Update `last_grant` to g.
- BUSY:
  - `alu_start` is high, and `alu_a`/`alu_b`/`alu_op` come from the holding registers, stable for the whole of BUSY.
  - On the first edge where `alu_done` is sampled high, capture `alu_result`, drop `alu_start`, and go to RESP.
- RESP:
  - `rsp_valid`=1, `rsp_id`=latched g, `rsp_result`=captured value.
  - Next state is IDLE. No request is accepted in RESP.
  - RESP guarantees at least one cycle with `alu_start` low between operations.
- Arithmetic: `rsp_result` is `alu_result` unmodified, full result_t width. The block does no computation itself.
- A requester holding `req_valid` high keeps it high, with stable payload, until it sees `req_ready`.
- Outside RESP, `rsp_result` holds its last value, while `rsp_id` and `rsp_error` are 0.

## Timing
- Reset values: state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `req_ready`=0, `alu_start`=0, `alu_a`/`alu_b`=0, `alu_op`=NOP, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_error`=0.
- Accept in cycle T:
  - `alu_start` is high from T+1.
  - If `alu_done` is sampled at the edge ending cycle D, `rsp_valid` is high in D+1 and the next accept can occur in D+2.
- NOP accepted at T: `rsp_valid` in T+1; next accept at T+2.
- Single-cycle ALU ops (done sampled at the end of T+1): `rsp_valid` at T+2, so minimum issue interval is 3 cycles.
- An `alu_done` arriving while not in BUSY is ignored.
- Several `req_valid` bits rising in the same cycle: exactly one grant, by round-robin order. The others wait; each waits at most NUM_REQ-1 grants.
- Reset asserted mid-BUSY: `alu_start` drops immediately (asynchronous). The in-flight operation is discarded and no response is issued.

## Configuration
- `TINYALU_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in BUSY and is cleared on entry.
  - If it reaches TIMEOUT with no `alu_done`: drop `alu_start`, go to RESP with `rsp_error`=1 and `rsp_result`=0.
  - If `alu_done` and expiry fall on the same edge, done wins and `rsp_error`=0.
- Not defined: no counter is built, BUSY waits indefinitely, and `rsp_error` is tied to 0.

## Structure
- `alu_pkg` owns operand_t (8-bit), result_t (16-bit) and opcode_t (3-bit enum: NOP, ADD, SUB, NOT, XOR, AND, MUL, INC), plus a new arb_state_t enum (IDLE, BUSY, RESP).
- One sub-module is natural: `rr_pick`, a combinational round-robin priority picker taking a request vector and last grant and returning a one-hot grant and index.

## Test plan
- Requester 0 only, A=8'd5, B=8'd3, op=ADD → one `req_ready[0]` pulse, `alu_start` held until done, then `rsp_valid` with `rsp_id`=0 and `rsp_result`=16'd8.
- Requester 2 sends MUL with A=8'hFF, B=8'hFF → `rsp_result`=16'hFE01, `rsp_id`=2, `alu_start` stays stable across the multi-cycle wait.
- All four requesters assert ADD at the same time after reset → grant order 0,1,2,3. Then requesters 3 and 0 assert again → order 0 then 3.
- NOP from requester 1 → `rsp_valid` exactly 1 cycle after accept with `rsp_result`=0, and `alu_start` never rises.
- `TINYALU_ARB_TIMEOUT_EN` defined, TIMEOUT=8, stub ALU that never asserts done → `alu_start` high for 8 cycles, then `rsp_error`=1 and `rsp_result`=0; the next request is served normally.
- `reset_n` pulsed low during BUSY → `alu_start` and `rsp_valid` are 0 immediately, no response is issued, and the next grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared tinyalu types: operand/result widths, opcode encoding and the arbiter state enum.
package alu_pkg;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] result_t;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        NOT = 3'd3,
        XOR = 3'd4,
        AND = 3'd5,
        MUL = 3'd6,
        INC = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       hit
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(last) + i) % NUM_REQ);
            if (!hit && req[cand]) begin
                hit         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin scheduler sharing one tinyalu among NUM_REQ requesters; tagged response bus.
// Define TINYALU_ARB_TIMEOUT_EN to build the BUSY watchdog that aborts after TIMEOUT cycles.
module tinyalu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  operand_t [NUM_REQ-1:0]     req_a,
    input  operand_t [NUM_REQ-1:0]     req_b,
    input  opcode_t  [NUM_REQ-1:0]     req_op,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output result_t                    rsp_result,
    output logic                       rsp_error,
    output logic                       alu_start,
    output operand_t                   alu_a,
    output operand_t                   alu_b,
    output opcode_t                    alu_op,
    input  result_t                    alu_result,
    input  logic                       alu_done
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("tinyalu_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_t          state;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     id_q;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_hit;
    operand_t            sel_a;
    operand_t            sel_b;
    opcode_t             sel_op;

`ifdef TINYALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] busy_cnt;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx),
        .hit   (pick_hit)
    );

    // Accept is combinational so the requester sees ready in the same cycle it is granted.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && pick_hit) begin
            req_ready = pick_grant;
        end
        sel_a  = req_a[pick_idx];
        sel_b  = req_b[pick_idx];
        sel_op = req_op[pick_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            alu_start  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= NOP;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
            busy_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        last_grant <= pick_idx;
                        id_q       <= pick_idx;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_op     <= sel_op;
                        if (sel_op == NOP) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_id     <= pick_idx;
                            rsp_result <= '0;
                        end else begin
                            state     <= BUSY;
                            alu_start <= 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
                            busy_cnt  <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    // Done takes priority over a watchdog expiry on the same edge.
                    if (alu_done) begin
                        state      <= RESP;
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_result <= alu_result;
                    end
`ifdef TINYALU_ARB_TIMEOUT_EN
                    else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_id    <= '0;
                    rsp_error <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    alu_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_id    <= '0;
                    rsp_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Scoreboard bench for tinyalu_arbiter with a behavioural tinyalu stub (MUL takes 3 cycles).
module tb_tinyalu_arbiter;
    import alu_pkg::*;

    logic            clk;
    logic            reset_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    operand_t [3:0]  req_a;
    operand_t [3:0]  req_b;
    opcode_t  [3:0]  req_op;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    result_t         rsp_result;
    logic            rsp_error;
    logic            alu_start;
    operand_t        alu_a;
    operand_t        alu_b;
    opcode_t         alu_op;
    result_t         alu_result;
    logic            alu_done;

    logic            hang;
    logic            force_done;
    logic [3:0]      busy_cnt;

    typedef struct {
        int       id;
        result_t  res;
        logic     err;
    } exp_t;

    exp_t    sb[$];
    int      exp_grant[$];
    int      checks = 0;
    int      errors = 0;
    result_t last_res = '0;

    tinyalu_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        busy_cnt <= alu_start ? busy_cnt + 4'd1 : 4'd0;
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ADD:     alu_result = 16'(alu_a) + 16'(alu_b);
            SUB:     alu_result = 16'(alu_a) - 16'(alu_b);
            NOT:     alu_result = {8'h00, ~alu_a};
            XOR:     alu_result = {8'h00, alu_a ^ alu_b};
            AND:     alu_result = {8'h00, alu_a & alu_b};
            MUL:     alu_result = 16'(alu_a) * 16'(alu_b);
            INC:     alu_result = 16'(alu_a) + 16'd1;
            default: alu_result = '0;
        endcase
        alu_done = force_done ||
                   (alu_start && !hang && busy_cnt == ((alu_op == MUL) ? 4'd2 : 4'd0));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input result_t r, input logic err);
        exp_t e;
        e.id  = id;
        e.res = r;
        e.err = err;
        sb.push_back(e);
    endtask

    // Response monitor: pops one expectation per rsp_valid, checks idle values otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_id", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
                last_res = e.res;
            end
        end else begin
            chk("idle_rsp", {rsp_error, 13'd0, rsp_id, rsp_result}, {16'd0, last_res});
        end
    end

    task automatic serve(input logic [3:0] mask);
        logic [3:0] pend;
        logic [3:0] g;
        int         n;
        int         e;
        pend = mask;
        n = 0;
        req_valid = req_valid | mask;
        while (pend != 4'd0 && n < 60) begin
            #1;
            if (req_ready != 4'd0) begin
                g = req_ready;
                if (exp_grant.size() == 0) begin
                    chk("grant_unexpected", 32'(g), 32'd0);
                end else begin
                    e = exp_grant.pop_front();
                    chk("grant", 32'(g), 32'(4'b0001 << e));
                end
                @(posedge clk);
                #1;
                req_valid = req_valid & ~g;
                pend = pend & ~g;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("grant_timeout", 32'(pend), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = {NOP, NOP, NOP, NOP};
        hang       = 1'b0;
        force_done = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(NOP));
        chk("rst_rsp", {rsp_valid, rsp_error, 12'd0, rsp_id, rsp_result}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD 5+3 from requester 0
        req_a[0] = 8'd5; req_b[0] = 8'd3; req_op[0] = ADD;
        exp_grant.push_back(0);
        push(0, 16'd8, 1'b0);
        serve(4'b0001);
        chk("add_start", 32'(alu_start), 32'd1);
        chk("add_operands", {8'd0, alu_a, alu_b, 5'd0, alu_op}, {8'd0, 8'd5, 8'd3, 5'd0, ADD});
        drain();

        // MUL FF*FF from requester 2, operands held across the wait
        req_a[2] = 8'hFF; req_b[2] = 8'hFF; req_op[2] = MUL;
        exp_grant.push_back(2);
        push(2, 16'hFE01, 1'b0);
        serve(4'b0100);
        for (int i = 0; i < 2; i++) begin
            chk("mul_hold", {7'd0, alu_start, alu_a, alu_b, 5'd0, alu_op},
                {7'd0, 1'b1, 8'hFF, 8'hFF, 5'd0, MUL});
            @(posedge clk);
            #1;
        end
        drain();

        // All four at once after reset, then 3 and 0 together
        do_reset();
        req_a[0] = 8'd1;   req_b[0] = 8'd2;   req_op[0] = ADD;
        req_a[1] = 8'd10;  req_b[1] = 8'd20;  req_op[1] = ADD;
        req_a[2] = 8'd100; req_b[2] = 8'd100; req_op[2] = ADD;
        req_a[3] = 8'd200; req_b[3] = 8'd100; req_op[3] = ADD;
        for (int i = 0; i < 4; i++) exp_grant.push_back(i);
        push(0, 16'd3, 1'b0);
        push(1, 16'd30, 1'b0);
        push(2, 16'd200, 1'b0);
        push(3, 16'd300, 1'b0);
        serve(4'b1111);
        drain();

        req_a[3] = 8'hAA; req_b[3] = 8'h0F; req_op[3] = XOR;
        req_a[0] = 8'hF0; req_b[0] = 8'h3C; req_op[0] = AND;
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        push(0, 16'h0030, 1'b0);
        push(3, 16'h00A5, 1'b0);
        serve(4'b1001);
        drain();

        // NOP from requester 1: response in the cycle after accept, ALU never started
        req_a[1] = 8'h77; req_b[1] = 8'h11; req_op[1] = NOP;
        exp_grant.push_back(1);
        push(1, 16'd0, 1'b0);
        serve(4'b0010);
        chk("nop_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("nop_rsp_result", 32'(rsp_result), 32'd0);
        chk("nop_start_t1", 32'(alu_start), 32'd0);
        @(posedge clk);
        #1;
        chk("nop_rsp_gone", 32'(rsp_valid), 32'd0);
        chk("nop_start_t2", 32'(alu_start), 32'd0);
        drain();

        // Stray done while idle produces nothing
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_done", {30'd0, rsp_valid, alu_start}, 32'd0);
        end
        force_done = 1'b0;
        @(negedge clk);

        // Reset during BUSY discards the operation and restarts the rotation at 0
        hang = 1'b1;
        req_a[1] = 8'd9; req_b[1] = 8'd9; req_op[1] = ADD;
        exp_grant.push_back(1);
        serve(4'b0010);
        chk("hang_start", 32'(alu_start), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        last_res = '0;
        #1;
        chk("async_rst_start", 32'(alu_start), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        req_a[0] = 8'd1;   req_b[0] = 8'd1;   req_op[0] = ADD;
        req_a[2] = 8'h0F;  req_b[2] = 8'h00;  req_op[2] = NOT;
        exp_grant.push_back(0);
        exp_grant.push_back(2);
        push(0, 16'd2, 1'b0);
        push(2, 16'h00F0, 1'b0);
        serve(4'b0101);
        drain();

`ifdef TINYALU_ARB_TIMEOUT_EN
        // Watchdog: ALU never answers, abort after TIMEOUT cycles, then normal service
        hang = 1'b1;
        req_a[3] = 8'd4; req_b[3] = 8'd4; req_op[3] = ADD;
        exp_grant.push_back(3);
        push(3, 16'd0, 1'b1);
        serve(4'b1000);
        n = 0;
        while (alu_start && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("timeout_start_cycles", 32'(n), 32'd8);
        drain();
        hang = 1'b0;
        req_a[1] = 8'd2; req_b[1] = 8'd2; req_op[1] = ADD;
        exp_grant.push_back(1);
        push(1, 16'd4, 1'b0);
        serve(4'b0010);
        drain();
`endif
        n = 0;

        repeat (3) @(negedge clk);
        chk("grants_consumed", 32'(exp_grant.size() + n), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
